// File: rtl/seven_seg_pkg.sv
// Shared types and segment constants for the 4-digit 7-segment scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b0111111;

    localparam seg_t SEG_DIGIT [0:9] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low segment pattern.
// Ports: bcd_i (digit in), seg_o (segments out); A..F decode to a dash.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  bcd_digit_t bcd_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_DIGIT[bcd_i];
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit 7-segment driver with double-buffered input.
// Ports: clk_in, reset (async, low), value_bcd/valid/ready handshake,
// blank_lz, display (segments), on_off (anodes), frame_done (pulse).
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] value_bcd,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic        blank_lz,
    output logic [6:0]  display,
    output logic [3:0]  on_off,
    output logic        frame_done
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic [15:0]   pending_q;
    logic [15:0]   active_q;
    logic          pend_full_q;
    logic          wrap_q;
    logic          frame_q;
    seg_t          disp_q;
    logic [3:0]    on_off_q;

    logic          tick;
    logic          wrap;
    logic          take;
    bcd_digit_t    cur_digit;
    seg_t          cur_seg;
    logic [3:0]    lz;
    logic          slot_blank;
    seg_t          disp_d;
    logic [3:0]    on_off_d;

    assign tick = (presc_q == PRESC_MAX);
    assign wrap = tick && (idx_q == 2'd3);
    assign take = value_valid && !pend_full_q;

    // lz[k]: digits k..3 of the shown value are all zero
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (active_q[15:12] == 4'd0);
        lz[2] = lz[3] && (active_q[11:8] == 4'd0);
        lz[1] = lz[2] && (active_q[7:4] == 4'd0);
    end

    always_comb begin
        cur_digit = active_q[3:0];
        unique case (idx_q)
            2'd0: cur_digit = active_q[3:0];
            2'd1: cur_digit = active_q[7:4];
            2'd2: cur_digit = active_q[11:8];
            2'd3: cur_digit = active_q[15:12];
        endcase
    end

    bcd_to_seg u_dec (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    assign slot_blank = blank_lz && lz[idx_q];

    always_comb begin
        disp_d   = cur_seg;
        on_off_d = ~(4'b0001 << idx_q);
        if (slot_blank) begin
            disp_d   = SEG_BLANK;
            on_off_d = 4'b1111;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            pending_q   <= 16'h0000;
            active_q    <= 16'h0000;
            pend_full_q <= 1'b0;
            wrap_q      <= 1'b0;
            frame_q     <= 1'b0;
            disp_q      <= SEG_BLANK;
            on_off_q    <= 4'b1111;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                idx_q <= idx_q + 2'd1;
            end
            // A commit and a transfer cannot coincide: transfer needs
            // the buffer empty, commit needs it full.
            if (wrap && pend_full_q) begin
                active_q    <= pending_q;
                pend_full_q <= 1'b0;
            end
            if (take) begin
                pending_q   <= value_bcd;
                pend_full_q <= 1'b1;
            end
            // Extra stage so the pulse lines up with digit 0 on the pins
            wrap_q   <= wrap;
            frame_q  <= wrap_q;
            disp_q   <= disp_d;
            on_off_q <= on_off_d;
        end
    end

    assign value_ready = !pend_full_q;
    assign display     = disp_q;
    assign on_off      = on_off_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with DIV=4.
// Reference model works from edge counts since reset release.
module tb_seven_seg_scanner;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_bcd = 16'h0000;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic        blank_lz = 1'b0;
    logic [6:0]  display;
    logic [3:0]  on_off;
    logic        frame_done;

    seven_seg_scanner #(.DIV(4)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .value_bcd   (value_bcd),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .blank_lz    (blank_lz),
        .display     (display),
        .on_off      (on_off),
        .frame_done  (frame_done)
    );

    always #5 clk_in = ~clk_in;

    int          vectors = 0;
    int          errors = 0;
    int          n = 0;
    logic [15:0] m_active = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    logic        m_full = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at n=%0d: observed %h expected %h",
                   tag, n, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_disp"}, 16'(display), 16'h007f);
        chk({tag, "_onoff"}, 16'(on_off), 16'h000f);
        chk({tag, "_rdy"}, 16'(value_ready), 16'h0001);
        chk({tag, "_fd"}, 16'(frame_done), 16'h0000);
    endtask

    // One clock edge: predict outputs from the rules, then compare.
    task automatic cyc();
        int         slot;
        logic [3:0] dg;
        logic       blk;
        logic [6:0] ed;
        logic [3:0] eo;
        logic       efd;
        logic       take;
        @(posedge clk_in);
        n++;
        slot = ((n - 1) / 4) % 4;
        dg   = 4'(m_active >> (4 * slot));
        blk  = blank_lz && (slot != 0) && ((m_active >> (4 * slot)) == 0);
        ed   = blk ? 7'b1111111 : seg_of(dg);
        eo   = blk ? 4'b1111 : ~(4'b0001 << slot);
        efd  = (n > 16) && ((n - 1) % 16 == 0);
        take = value_valid && !m_full;
        if ((n % 16 == 0) && m_full) begin
            m_active = m_pend;
            m_full   = 1'b0;
        end
        if (take) begin
            m_pend = value_bcd;
            m_full = 1'b1;
        end
        #1;
        chk("display", 16'(display), 16'(ed));
        chk("on_off", 16'(on_off), 16'(eo));
        chk("frame_done", 16'(frame_done), 16'(efd));
        chk("value_ready", 16'(value_ready), 16'(!m_full));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    task automatic model_reset();
        n        = 0;
        m_active = 16'h0000;
        m_pend   = 16'h0000;
        m_full   = 1'b0;
    endtask

    task automatic offer(input logic [15:0] v);
        value_bcd   = v;
        value_valid = 1'b1;
        cyc();
        value_valid = 1'b0;
    endtask

    initial begin
        // Power-on reset, checked before any clock edge
        #2 reset = 1'b0;
        #1 chk_reset_vals("por_async");
        repeat (3) @(posedge clk_in);
        #1 chk_reset_vals("por_held");
        reset = 1'b1;
        model_reset();

        // Free-running scan
        run(40);

        // Single offer and commit
        offer(16'h1234);
        run(40);

        // Back-pressure: second value held behind the first
        value_bcd   = 16'h5678;
        value_valid = 1'b1;
        cyc();
        value_bcd = 16'h9999;
        for (int i = 0; i < 40; i++) begin
            if (m_full && m_pend == 16'h9999) break;
            cyc();
        end
        value_valid = 1'b0;
        chk("bp_taken", {15'd0, m_full}, 16'h0001);
        run(40);

        // Leading-zero blanking
        blank_lz = 1'b1;
        offer(16'h0070);
        run(40);
        offer(16'h0000);
        run(40);

        // Invalid nibble
        blank_lz = 1'b0;
        offer(16'h00A5);
        run(40);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) blank_lz = $urandom_range(0, 1) == 1;
            value_bcd   = 16'($urandom);
            value_valid = $urandom_range(0, 3) == 0;
            cyc();
        end
        value_valid = 1'b0;
        run(20);

        // Mid-frame async reset with a value pending
        offer(16'h4321);
        run(5);
        reset = 1'b0;
        #1 chk_reset_vals("mid_async");
        repeat (2) @(posedge clk_in);
        #1 chk_reset_vals("mid_held");
        reset = 1'b1;
        model_reset();
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
